// File: rtl/emu_clk_val_gen.sv
// Emulated oscillator: registered clk_val request and dt_req timestep bound.
// Optional sticky timestep-violation flag dt_err under EMU_CLK_VAL_ERR_EN.
module emu_clk_val_gen #(
  parameter int DT_WIDTH = 32
) (
  input  logic                emu_clk,
  input  logic                emu_rst,
  input  logic                cke,
  input  logic [DT_WIDTH-1:0] half_period_lo,
  input  logic [DT_WIDTH-1:0] half_period_hi,
  input  logic [DT_WIDTH-1:0] emu_dt,
  output logic [DT_WIDTH-1:0] dt_req,
  output logic                clk_val
`ifdef EMU_CLK_VAL_ERR_EN
  ,
  output logic                dt_err
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2
  } state_e;

  localparam logic [DT_WIDTH-1:0] DT_MAX = {DT_WIDTH{1'b1}};
  localparam logic [DT_WIDTH-1:0] DT_ONE = {{(DT_WIDTH-1){1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [DT_WIDTH-1:0] t_rem_q, t_rem_d;
  logic [DT_WIDTH-1:0] dt_req_q, dt_req_d;
  logic                clk_val_q, clk_val_d;
  logic                viol;

  // A zero-length phase would never let time advance, so load at least 1.
  function automatic logic [DT_WIDTH-1:0] clamp(
    input logic [DT_WIDTH-1:0] x
  );
    return (x == '0) ? DT_ONE : x;
  endfunction

  always_comb begin
    state_d   = state_q;
    t_rem_d   = t_rem_q;
    clk_val_d = clk_val_q;
    viol      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cke) begin
          state_d   = LO;
          t_rem_d   = clamp(half_period_lo);
          clk_val_d = 1'b0;
        end
      end
      LO, HI: begin
        if (cke && emu_dt != '0) begin
          if (emu_dt >= t_rem_q) begin
            viol = emu_dt > t_rem_q;
            if (state_q == LO) begin
              state_d   = HI;
              t_rem_d   = clamp(half_period_hi);
              clk_val_d = 1'b1;
            end else begin
              state_d   = LO;
              t_rem_d   = clamp(half_period_lo);
              clk_val_d = 1'b0;
            end
          end else begin
            t_rem_d = t_rem_q - emu_dt;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        t_rem_d   = '0;
        clk_val_d = 1'b0;
      end
    endcase
    dt_req_d = (cke && state_d != IDLE) ? t_rem_d : DT_MAX;
  end

  always_ff @(posedge emu_clk or posedge emu_rst) begin
    if (emu_rst) begin
      state_q   <= IDLE;
      t_rem_q   <= '0;
      dt_req_q  <= DT_MAX;
      clk_val_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      t_rem_q   <= t_rem_d;
      dt_req_q  <= dt_req_d;
      clk_val_q <= clk_val_d;
    end
  end

  assign dt_req  = dt_req_q;
  assign clk_val = clk_val_q;

`ifdef EMU_CLK_VAL_ERR_EN
  logic dt_err_q, dt_err_d;

  always_comb begin
    dt_err_d = dt_err_q | viol;
  end

  always_ff @(posedge emu_clk or posedge emu_rst) begin
    if (emu_rst) begin
      dt_err_q <= 1'b0;
    end else begin
      dt_err_q <= dt_err_d;
    end
  end

  assign dt_err = dt_err_q;
`else
  logic unused_viol;
  assign unused_viol = viol;
`endif

endmodule
